// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
// Shared types and helpers for the ROM fetch arbiter.
//   state_t      : arbiter sequencing states (IDLE, READ, RESP)
//   port_t       : requester identity (PORT_I = instruction fetch, PORT_D = data/debug)
//   ROM_BYTES_DEF: default ROM capacity in bytes
//   addr_legal() : word-aligned and inside the ROM (unsigned compare)
// -----------------------------------------------------------------------------
package rom_arb_pkg;

    localparam int ROM_BYTES_DEF = 100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Callers zero-extend to 64 bits so the compare is unsigned on the full
    // address width; the last legal word starts at rom_bytes-4.
    function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] rom_bytes);
        return (addr[1:0] == 2'b00) && (addr <= rom_bytes - 64'd4);
    endfunction

endpackage

// File: rtl/rom_rr_arb.sv
// -----------------------------------------------------------------------------
// rom_rr_arb
// Two-request round-robin picker. Holds the port granted most recently and,
// on a tie, grants the other one; a lone request is granted outright.
// Ports:
//   CLK, RST_n  : clock, asynchronous active-low reset (last resets to PORT_D)
//   i_vld_i     : port I request valid
//   i_vld_d     : port D request valid
//   i_update    : a grant was taken this cycle; remember who won
//   o_gnt_i     : one-hot grant, port I (combinational)
//   o_gnt_d     : one-hot grant, port D (combinational)
// -----------------------------------------------------------------------------
module rom_rr_arb
    import rom_arb_pkg::*;
(
    input  logic CLK,
    input  logic RST_n,
    input  logic i_vld_i,
    input  logic i_vld_d,
    input  logic i_update,
    output logic o_gnt_i,
    output logic o_gnt_d
);

    port_t r_last;

    always_comb begin
        o_gnt_i = i_vld_i;
        o_gnt_d = i_vld_d;
        if (i_vld_i && i_vld_d) begin
            o_gnt_i = (r_last == PORT_D);
            o_gnt_d = (r_last == PORT_I);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_last <= PORT_D;
        end else if (i_update) begin
            r_last <= o_gnt_d ? PORT_D : PORT_I;
        end
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// rom_fetch_arbiter
// Shares one big-endian, byte-addressed instruction ROM between the
// instruction-fetch port (I) and the data/debug read port (D). One word read
// is in flight at a time: accept in IDLE, strobe the ROM in READ, then hold
// the registered word in RESP until the owning port takes it.
//
// Build option: define ROM_ARB_CHECK_EN to enable the alignment/range check.
// Illegal addresses then skip the ROM and answer with rsp_err=1, rsp_data=0,
// and the extra err_cnt output counts error responses (saturating at 255).
// Without it every request is read and rsp_err is tied low.
//
// Ports:
//   CLK, RST_n                 clock, asynchronous active-low reset
//   i_req_valid/addr/ready     port I request handshake
//   d_req_valid/addr/ready     port D request handshake
//   i_rsp_valid/ready          port I response handshake
//   d_rsp_valid/ready          port D response handshake
//   rsp_data, rsp_err          shared response word / address-fault flag
//   rom_rd, rom_addr           ROM strobe (active low) and byte address
//   rom_data                   ROM word, combinational from rom_addr
//   err_cnt                    saturating error count (ROM_ARB_CHECK_EN only)
//
// state | meaning
// IDLE  | waiting for a request; req_ready follows the round-robin grant
// READ  | rom_rd low on the latched address; word captured at end of cycle
// RESP  | owning port's rsp_valid high until its rsp_ready
// -----------------------------------------------------------------------------
module rom_fetch_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ROM_BYTES = ROM_BYTES_DEF,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
`ifdef ROM_ARB_CHECK_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    if (ROM_BYTES < 4 || (ROM_BYTES % 4) != 0 || DATA_W != 32) begin : g_bad_cfg
        $error("rom_fetch_arbiter: ROM_BYTES must be a positive multiple of 4 and DATA_W must be 32");
    end

    state_t            r_state;
    port_t             r_owner;
    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_idle;
    logic              w_accept;
    port_t             w_req_port;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_rsp_take;

    rom_rr_arb u_rr_arb (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .i_vld_i  (i_req_valid),
        .i_vld_d  (d_req_valid),
        .i_update (w_accept),
        .o_gnt_i  (w_gnt_i),
        .o_gnt_d  (w_gnt_d)
    );

    // Gating with RST_n keeps both readies low while reset is held even
    // though the state register already reads IDLE.
    assign w_idle      = (r_state == IDLE) && RST_n;
    assign i_req_ready = w_idle && w_gnt_i;
    assign d_req_ready = w_idle && w_gnt_d;
    assign w_accept    = i_req_ready || d_req_ready;
    assign w_req_port  = w_gnt_d ? PORT_D : PORT_I;
    assign w_req_addr  = w_gnt_d ? d_req_addr : i_req_addr;
    assign w_rsp_take  = (r_owner == PORT_I) ? i_rsp_ready : d_rsp_ready;

`ifdef ROM_ARB_CHECK_EN
    logic w_legal;
    assign w_legal = addr_legal(64'(w_req_addr), 64'(ROM_BYTES));
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= IDLE;
            r_owner     <= PORT_I;
            rom_rd      <= 1'b1;
            rom_addr    <= '0;
            rsp_data    <= '0;
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
`ifdef ROM_ARB_CHECK_EN
            rsp_err     <= 1'b0;
            err_cnt     <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_req_port;
`ifdef ROM_ARB_CHECK_EN
                        if (!w_legal) begin
                            // Fault answered straight from IDLE; rom_addr keeps its old value.
                            rsp_data    <= '0;
                            rsp_err     <= 1'b1;
                            i_rsp_valid <= (w_req_port == PORT_I);
                            d_rsp_valid <= (w_req_port == PORT_D);
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            r_state <= RESP;
                        end else begin
                            rom_addr <= w_req_addr;
                            rom_rd   <= 1'b0;
                            r_state  <= READ;
                        end
`else
                        rom_addr <= w_req_addr;
                        rom_rd   <= 1'b0;
                        r_state  <= READ;
`endif
                    end
                end
                READ: begin
                    rsp_data    <= rom_data;
`ifdef ROM_ARB_CHECK_EN
                    rsp_err     <= 1'b0;
`endif
                    rom_rd      <= 1'b1;
                    i_rsp_valid <= (r_owner == PORT_I);
                    d_rsp_valid <= (r_owner == PORT_D);
                    r_state     <= RESP;
                end
                RESP: begin
                    if (w_rsp_take) begin
                        i_rsp_valid <= 1'b0;
                        d_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    rom_rd      <= 1'b1;
                    i_rsp_valid <= 1'b0;
                    d_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rom_fetch_arbiter.md
# rom_fetch_arbiter

Shares the single big-endian, byte-addressed, 100-byte instruction ROM between two requesters: the instruction-fetch port (I) and the data/debug read port (D). It sequences each access as a one-word read with an active-low ROM read strobe, registers the returned word, and holds it for the requester under a valid/ready handshake. It sits between the PC/fetch logic and the ROM, with the D port serving load-from-ROM and debug readback.

## Interface
- ROM_BYTES, 100, ROM capacity in bytes; the highest legal word address is ROM_BYTES-4.
- ADDR_W, 32, address width.
- DATA_W, 32, word width; fixed at 4 bytes.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- i_req_valid / d_req_valid  in  1  request pending on port I / D.
- i_req_addr / d_req_addr  in  ADDR_W  byte address of the requested word.
- i_req_ready / d_req_ready  out  1  request accepted this cycle.
- i_rsp_valid / d_rsp_valid  out  1  response word available.
- i_rsp_ready / d_rsp_ready  in  1  requester consumes the response.
- rsp_data  out  DATA_W  response word, shared by both ports and valid with the active rsp_valid.
- rsp_err  out  1  response is an address fault.
- rom_rd  out  1  ROM read strobe; 0 means read.
- rom_addr  out  ADDR_W  ROM byte address.
- rom_data  in  DATA_W  ROM word, combinational from rom_addr; byte at addr is [31:24].

## Operation
- FSM states are IDLE, READ and RESP.
- **IDLE**
  - Grant one valid port. req_ready is combinational and high only for the granted port.
  - On acceptance, latch the address and port id.
  - Legal address: next state READ. Illegal address (only when the check is compiled in): next state RESP with err.
- **READ**
  - Drive rom_rd=0 and rom_addr to the latched address.
  - Capture rom_data into rsp_data at the end of the cycle.
  - Next state RESP.
- **RESP**
  - Assert the owning port's rsp_valid.
  - Hold rsp_data and rsp_err stable until that port's rsp_ready is high. The state is left on that edge, and the next state is IDLE.
- **Arbitration**
  - 2-way round-robin. `last` records the port granted most recently.
  - When both ports are valid, grant the port other than `last`. A lone valid port is granted regardless of `last`.
  - `last` resets to D, so I wins the first tie.
- **Address legality**
  - Legal means addr[1:0]==0 and addr <= ROM_BYTES-4, compared unsigned on the full ADDR_W width.
- **Idle outputs**
  - Outside READ: rom_rd=1 and rom_addr holds its last value.
- **No pipelining**
  - At most one transaction is in flight. Both req_ready are 0 in READ and RESP.
- **Requester behaviour**
  - A requester may drop req_valid before it is accepted; nothing is issued.
  - A request that loses arbitration stays pending.

## Timing
- Reset values:
  - state=IDLE, last=D, rom_rd=1, rom_addr=0.
  - rsp_data=0, rsp_err=0, both rsp_valid=0.
  - Both req_ready=0 while RST_n is low.
- Latency for a legal request accepted in cycle N:
  - rom_rd=0 in cycle N+1.
  - rsp_valid in cycle N+2.
  - With rsp_ready already high, the next acceptance is in cycle N+3. Sustained throughput is 1 word per 3 cycles.
- Latency for an illegal request accepted in cycle N: rsp_valid with rsp_err=1 and rsp_data=0 in cycle N+1. The ROM is not strobed.
- Backpressure: RESP holds indefinitely. The other port's request waits, and its ready stays 0.
- Simultaneous events:
  - rsp_ready in RESP together with a new req_valid: the new request is accepted in the following IDLE cycle, not the same cycle.
- Reset mid-operation: the transaction in flight is dropped with no response, and rom_rd returns to 1 asynchronously.

## Configuration
- ROM_ARB_CHECK_EN defined:
  - Alignment and range check active, with error responses as above.
  - Adds err_cnt, an 8-bit output: a saturating count of error responses, reset 0, held at 255.
- ROM_ARB_CHECK_EN undefined:
  - Every request goes through READ.
  - rsp_err is tied to 0 and the err_cnt port is absent.
  - Addresses pass to the ROM unchanged; reads outside the range are undefined.

## Structure
- Package rom_arb_pkg holds:
  - the state enum (IDLE, READ, RESP);
  - the port-id typedef (PORT_I, PORT_D);
  - the ROM_BYTES default;
  - the legality function.
- Sub-module rom_rr_arb: a 2-request round-robin picker holding `last`. Inputs are the two valid bits and an update strobe; outputs are the one-hot grant.

## Test plan
- I reads 0x0 with ROM bytes 0x20,0x08,0x00,0x01 -> rom_rd low in N+1; i_rsp_valid in N+2 with rsp_data=0x20080001 and rsp_err=0.
- I and D both valid from reset (addresses 0x4 and 0x8) for 3 rounds -> grant order I, D, I; each response goes to the correct port.
- D holds d_rsp_ready=0 for 5 cycles while I is pending -> rsp_data stable, i_req_ready=0 throughout; I is accepted the cycle after the D handshake.
- With ROM_ARB_CHECK_EN: D reads 0x2, then 0x60 (96), then 0x64 (100):
  - 0x2 -> rsp_err=1, rsp_data=0, no rom_rd pulse, err_cnt=1.
  - 0x60 -> legal read.
  - 0x64 -> err, err_cnt=2.
- RST_n asserted in READ -> rom_rd=1 immediately; after release there is no rsp_valid, and I wins the next tie.
- 256 illegal requests with the check enabled -> err_cnt saturates at 255.
